// File: rtl/multicycle_control_fsm.sv
// Control sequencer for the multi-cycle MIPS datapath (ADD/SUB/AND/OR/SLT/ADDI/LW/SW/BEQ/J).
// Define MC_PERF_COUNT_EN to add cycle_cnt_out / instr_cnt_out performance counters.
module multicycle_control_fsm #(
    parameter int unsigned CNT_W = 32
) (
    input  logic       clk_in,
    input  logic       reset_n_in,
    input  logic [5:0] op_in,
    input  logic [5:0] func_in,
    input  logic       mem_ready_in,
    output logic       pc_write_out,
    output logic       branch_out,
    output logic       iord_out,
    output logic       mem_read_out,
    output logic       mem_write_out,
    output logic       ir_write_out,
    output logic       mem_to_reg_out,
    output logic       reg_dst_out,
    output logic       reg_write_out,
    output logic       alu_src_a_out,
    output logic [1:0] alu_src_b_out,
    output logic [1:0] alu_op_out,
    output logic [1:0] pc_src_out,
    output logic [3:0] state_out,
    output logic       illegal_op_out
`ifdef MC_PERF_COUNT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt_out,
    output logic [CNT_W-1:0] instr_cnt_out
`endif
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_R_EX    = 4'd6,
        S_R_WB    = 4'd7,
        S_BEQ_EX  = 4'd8,
        S_ADDI_EX = 4'd9,
        S_ADDI_WB = 4'd10,
        S_JUMP    = 4'd11,
        S_TRAP    = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    state_e state_q, state_d;
    logic   func_legal;

    assign func_legal = func_in inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) state_q <= S_FETCH;
        else             state_q <= state_d;
    end

    // Next-state decode; mem_ready_in only matters in the three memory-access states.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:   if (mem_ready_in) state_d = S_DECODE;
            S_DECODE: begin
                case (op_in)
                    OP_RTYPE:     state_d = func_legal ? S_R_EX : S_TRAP;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_ADDI:      state_d = S_ADDI_EX;
                    OP_BEQ:       state_d = S_BEQ_EX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEMADR:  state_d = (op_in == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   if (mem_ready_in) state_d = S_MEMWB;
            S_MEMWB:   state_d = S_FETCH;
            S_MEMWR:   if (mem_ready_in) state_d = S_FETCH;
            S_R_EX:    state_d = S_R_WB;
            S_R_WB:    state_d = S_FETCH;
            S_BEQ_EX:  state_d = S_FETCH;
            S_ADDI_EX: state_d = S_ADDI_WB;
            S_ADDI_WB: state_d = S_FETCH;
            S_JUMP:    state_d = S_FETCH;
            default:   state_d = S_TRAP;
        endcase
    end

    // Control decode from the state register, forced to zero while reset is held.
    always_comb begin
        pc_write_out   = 1'b0;
        branch_out     = 1'b0;
        iord_out       = 1'b0;
        mem_read_out   = 1'b0;
        mem_write_out  = 1'b0;
        ir_write_out   = 1'b0;
        mem_to_reg_out = 1'b0;
        reg_dst_out    = 1'b0;
        reg_write_out  = 1'b0;
        alu_src_a_out  = 1'b0;
        alu_src_b_out  = 2'b00;
        alu_op_out     = 2'b00;
        pc_src_out     = 2'b00;
        illegal_op_out = 1'b0;
        state_out      = 4'd0;
        if (reset_n_in) begin
            state_out = state_q;
            case (state_q)
                S_FETCH: begin
                    mem_read_out  = 1'b1;
                    alu_src_b_out = 2'b01;
                    ir_write_out  = mem_ready_in;
                    pc_write_out  = mem_ready_in;
                end
                S_DECODE:  alu_src_b_out = 2'b11;
                S_MEMADR: begin
                    alu_src_a_out = 1'b1;
                    alu_src_b_out = 2'b10;
                end
                S_MEMRD: begin
                    iord_out     = 1'b1;
                    mem_read_out = 1'b1;
                end
                S_MEMWB: begin
                    mem_to_reg_out = 1'b1;
                    reg_write_out  = 1'b1;
                end
                S_MEMWR: begin
                    iord_out      = 1'b1;
                    mem_write_out = 1'b1;
                end
                S_R_EX: begin
                    alu_src_a_out = 1'b1;
                    alu_op_out    = 2'b10;
                end
                S_R_WB: begin
                    reg_dst_out   = 1'b1;
                    reg_write_out = 1'b1;
                end
                S_BEQ_EX: begin
                    alu_src_a_out = 1'b1;
                    alu_op_out    = 2'b01;
                    pc_src_out    = 2'b01;
                    branch_out    = 1'b1;
                end
                S_ADDI_EX: begin
                    alu_src_a_out = 1'b1;
                    alu_src_b_out = 2'b10;
                end
                S_ADDI_WB: reg_write_out = 1'b1;
                S_JUMP: begin
                    pc_src_out   = 2'b10;
                    pc_write_out = 1'b1;
                end
                S_TRAP:  illegal_op_out = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef MC_PERF_COUNT_EN
    logic [CNT_W-1:0] cycle_cnt_q, instr_cnt_q;

    // Instruction count ticks on each completed instruction's return to FETCH.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            if (state_q != S_TRAP) cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
            if (state_q != S_FETCH && state_d == S_FETCH) instr_cnt_q <= instr_cnt_q + CNT_W'(1);
        end
    end

    assign cycle_cnt_out = cycle_cnt_q;
    assign instr_cnt_out = instr_cnt_q;
`endif

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Moore-style sequencer for the multi-cycle MIPS datapath. Supports ADD, SUB, AND, OR, SLT, ADDI, LW, SW, BEQ and J.
- Drives register-file, ALU, memory, IR and PC enables from a 13-state FSM.
- Stalls on a shared instruction/data memory through a ready handshake.
- Traps on unsupported opcode or funct.

Parameters:
CNT_W, 32, width of performance counters (used only with MC_PERF_COUNT_EN)

Ports:
clk_in  input  1  clock, rising edge
reset_n_in  input  1  asynchronous active-low reset
op_in  input  6  IR[31:26]; valid from DECODE onward
func_in  input  6  IR[5:0]; valid from DECODE onward
mem_ready_in  input  1  memory completes the current read/write this cycle
pc_write_out  output  1  unconditional PC load
branch_out  output  1  PC load qualified by ALU zero (datapath ANDs)
iord_out  output  1  memory address: 0=PC, 1=ALUOut
mem_read_out  output  1  memory read request
mem_write_out  output  1  memory write request
ir_write_out  output  1  IR load
mem_to_reg_out  output  1  write-back data: 0=ALUOut, 1=MDR
reg_dst_out  output  1  destination: 0=rt, 1=rd
reg_write_out  output  1  register file write
alu_src_a_out  output  1  0=PC, 1=regA
alu_src_b_out  output  2  00=regB, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
alu_op_out  output  2  00=add, 01=subtract, 10=decode funct
pc_src_out  output  2  00=ALU result, 01=ALUOut, 10=jump target
state_out  output  4  current state code
illegal_op_out  output  1  sticky trap flag

Behaviour:
- Reset:
  - reset_n_in=0 asynchronously forces state=FETCH(0).
  - While reset is asserted, every output including state_out is forced to 0.
  - FETCH outputs appear after release.
- State codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, R_EX=6, R_WB=7, BEQ_EX=8, ADDI_EX=9, ADDI_WB=10, JUMP=11, TRAP=12.
- Any output not listed for a state is 0.
- FETCH:
  - Outputs: mem_read=1, iord=0, src_a=0, src_b=01, alu_op=00, pc_src=00.
  - ir_write and pc_write = mem_ready_in. These are the only Mealy outputs.
  - Advance to DECODE only when mem_ready_in=1; otherwise hold.
- DECODE:
  - Outputs: src_a=0, src_b=11, alu_op=00 (precompute branch target).
  - Next state by op_in:
    - 000000 → R_EX if func_in ∈ {100000, 100010, 100100, 100101, 101010}, else TRAP
    - 100011 or 101011 → MEMADR
    - 001000 → ADDI_EX
    - 000100 → BEQ_EX
    - 000010 → JUMP
    - any other op → TRAP
- MEMADR: src_a=1, src_b=10, alu_op=00. Next: MEMRD if op=LW, MEMWR if op=SW.
- MEMRD: iord=1, mem_read=1. Hold until mem_ready_in=1, then MEMWB.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1. Next: FETCH.
- MEMWR: iord=1, mem_write=1. Hold until mem_ready_in=1, then FETCH.
- R_EX: src_a=1, src_b=00, alu_op=10. Next: R_WB.
- R_WB: reg_dst=1, mem_to_reg=0, reg_write=1. Next: FETCH.
- BEQ_EX: src_a=1, src_b=00, alu_op=01, pc_src=01, branch=1. Next: FETCH.
- ADDI_EX: src_a=1, src_b=10, alu_op=00. Next: ADDI_WB.
- ADDI_WB: reg_dst=0, mem_to_reg=0, reg_write=1. Next: FETCH.
- JUMP: pc_src=10, pc_write=1. Next: FETCH.
- TRAP: all enables 0, illegal_op_out=1. Absorbing; only reset exits. mem_ready_in is ignored.
- Latencies with mem_ready_in held high:
  - LW 5 cycles
  - SW, R-type, ADDI 4 cycles
  - BEQ, J 3 cycles
- Each memory wait cycle adds 1.
- mem_ready_in is ignored outside FETCH, MEMRD and MEMWR.
- Invariants:
  - mem_read and mem_write are never both 1.
  - reg_write and mem_write are never both 1.
  - pc_write and ir_write pulse exactly once per fetch.
- Reset asserted mid-instruction (e.g. during a MEMRD stall) aborts immediately; no partial write-back occurs.

Optional Feature:
MC_PERF_COUNT_EN:
- Defined:
  - Adds outputs cycle_cnt_out[CNT_W-1:0] and instr_cnt_out[CNT_W-1:0], both reset to 0.
  - cycle_cnt_out increments every cycle except in TRAP.
  - instr_cnt_out increments on each transition into FETCH from a non-FETCH state.
  - Both wrap modulo 2^CNT_W.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
1. Release reset, mem_ready_in=1, op=100011 → state_out 0,1,2,3,4,0. In state 4: reg_write=1, mem_to_reg=1, reg_dst=0.
2. FETCH with mem_ready_in=0 for 3 cycles, then 1 → state stays 0 with mem_read=1 and ir_write=0 for 3 cycles. ir_write and pc_write are 1 only in cycle 4, then DECODE.
3. op=000000, func=101010 → 0,1,6,7,0 with alu_op=10 in state 6 and reg_dst=1 in state 7. func=000011 → TRAP.
4. op=000100 → 0,1,8,0 with branch=1, pc_src=01, alu_op=01 in state 8. op=000010 → 0,1,11,0 with pc_write=1, pc_src=10.
5. op=111111 → state 12, illegal_op_out=1 for 10 cycles with mem_ready toggling. reset_n_in=0 clears it; the next instruction runs normally.
6. reset_n_in=0 mid-cycle during a MEMRD stall → all outputs 0 before the next clock edge, state 0 after release. With MC_PERF_COUNT_EN and CNT_W=4, run 17 one-cycle-fetch J instructions → instr_cnt_out=1 (wrapped).
